// File: rtl/simon_sequencer.sv
// Simon game sequencer: requests one random pad code per round, plays the growing
// sequence back to the renderer, then checks the player's presses against it.
module simon_sequencer #(
    parameter int MAX_LEN     = 16,
    parameter int SHOW_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 12_500_000,
    parameter int LW          = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [3:0]    step,
    input  logic [2:0]    randnum,
    input  logic          randReady,
    input  logic          btn_valid,
    input  logic [2:0]    btn_code,
    output logic [2:0]    show_code,
    output logic [LW-1:0] level,
    output logic          win,
    output logic          fail
);
    localparam int IW   = $clog2(MAX_LEN);
    localparam int TMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
    localparam logic [LW-1:0] LEVEL_MAX = LW'(MAX_LEN);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] REQ      = 3'd1;
    localparam logic [2:0] SETTLE   = 3'd2;
    localparam logic [2:0] SHOW_ON  = 3'd3;
    localparam logic [2:0] SHOW_OFF = 3'd4;
    localparam logic [2:0] INPUT    = 3'd5;
    localparam logic [2:0] WIN      = 3'd6;
    localparam logic [2:0] FAIL     = 3'd7;

    logic [2:0]    state;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nxt;
    logic [TW-1:0] timer;
    logic [2:0]    seq_buf [MAX_LEN];
    logic          code_ok;
    logic          idx_last;

    assign code_ok  = (randnum != 3'd0) && (randnum <= 3'd4);
    assign idx_nxt  = idx + 1'b1;
    assign idx_last = (LW'(idx) == (level - 1'b1));

    // Sequence storage carries no reset; only entries below level are ever read.
    always_ff @(posedge clk) begin
        if (state == SETTLE && code_ok)
            seq_buf[level[IW-1:0]] <= randnum;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            step      <= 4'b0000;
            show_code <= 3'd0;
            level     <= '0;
            win       <= 1'b0;
            fail      <= 1'b0;
            idx       <= '0;
            timer     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    level <= '0;
                    step  <= 4'b0001;
                    state <= REQ;
                end
                REQ: if (randReady) begin
                    step  <= 4'b0000;
                    state <= SETTLE;
                end
                SETTLE: if (code_ok) begin
                    level     <= level + 1'b1;
                    idx       <= '0;
                    timer     <= '0;
                    // first round: buffer slot 0 is being written this same edge
                    show_code <= (level == '0) ? randnum : seq_buf[0];
                    state     <= SHOW_ON;
                end else begin
                    step  <= 4'b0001;
                    state <= REQ;
                end
                SHOW_ON: if (timer == SHOW_LAST) begin
                    timer     <= '0;
                    show_code <= 3'd0;
                    state     <= SHOW_OFF;
                end else begin
                    timer <= timer + 1'b1;
                end
                SHOW_OFF: if (timer == GAP_LAST) begin
                    timer <= '0;
                    if (idx_last) begin
                        idx   <= '0;
                        state <= INPUT;
                    end else begin
                        idx       <= idx_nxt;
                        show_code <= seq_buf[idx_nxt];
                        state     <= SHOW_ON;
                    end
                end else begin
                    timer <= timer + 1'b1;
                end
                INPUT: if (btn_valid) begin
                    if (btn_code != seq_buf[idx]) begin
                        fail  <= 1'b1;
                        state <= FAIL;
                    end else if (!idx_last) begin
                        idx <= idx_nxt;
                    end else if (level == LEVEL_MAX) begin
                        win   <= 1'b1;
                        state <= WIN;
                    end else begin
                        idx   <= '0;
                        step  <= 4'b0001;
                        state <= REQ;
                    end
                end
                WIN, FAIL: if (start) begin
                    win   <= 1'b0;
                    fail  <= 1'b0;
                    level <= '0;
                    step  <= 4'b0001;
                    state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_simon_sequencer.sv
// Bench for simon_sequencer: models the random block, scoreboards playback and
// walks table-driven press sequences through win, fail and discard cases.
module tb_simon_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] step;
    logic [2:0] randnum = 3'd0;
    logic       randReady = 1'b0;
    logic       btn_valid = 1'b0;
    logic [2:0] btn_code = 3'd0;
    logic [2:0] show_code;
    logic [1:0] level;
    logic       win;
    logic       fail;

    simon_sequencer #(.MAX_LEN(3), .SHOW_CYCLES(4), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .step(step), .randnum(randnum),
        .randReady(randReady), .btn_valid(btn_valid), .btn_code(btn_code),
        .show_code(show_code), .level(level), .win(win), .fail(fail));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] show;
        logic [1:0] lvl;
        logic [3:0] stp;
    } obs_t;

    typedef struct {
        int         round;
        logic [2:0] code;
        logic [3:0] stp;
        logic [1:0] lvl;
        logic       w;
        logic       f;
    } row_t;

    int         n_vec = 0;
    int         n_miss = 0;
    logic [2:0] rand_q[$];
    logic [2:0] seq[$];
    obs_t       exp_q[$];
    row_t       rows[10];

    // Random block: acknowledge one cycle after a request, data the cycle after that.
    always @(posedge clk or negedge rst) begin
        logic rr;
        logic [3:0] sp;
        if (!rst) begin
            randReady = 1'b0;
            randnum   = 3'd0;
        end else begin
            rr = randReady;
            sp = step;
            #1;
            if (rr) begin
                randReady = 1'b0;
                randnum   = (rand_q.size() > 0) ? rand_q.pop_front() : 3'd1;
            end else if (sp == 4'b0001) begin
                randReady = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string nm, input logic [3:0] s, input logic [2:0] sh,
                            input logic [1:0] l, input logic w, input logic f);
        chk({nm, "_step"}, 32'(step), 32'(s));
        chk({nm, "_show"}, 32'(show_code), 32'(sh));
        chk({nm, "_level"}, 32'(level), 32'(l));
        chk({nm, "_win"}, 32'(win), 32'(w));
        chk({nm, "_fail"}, 32'(fail), 32'(f));
    endtask

    task automatic give_code(input logic [2:0] c);
        rand_q.push_back(c);
        if (c >= 3'd1 && c <= 3'd4) seq.push_back(c);
    endtask

    // Expected per-cycle outputs from the request edge through the last gap cycle.
    // The first entry (the request edge itself) is checked by the caller.
    task automatic push_play(input int prev, input int r, input int retries);
        obs_t t[$];
        for (int k = 0; k <= retries; k++) begin
            t.push_back('{3'd0, 2'(prev), 4'd1});
            t.push_back('{3'd0, 2'(prev), 4'd1});
            t.push_back('{3'd0, 2'(prev), 4'd0});
        end
        for (int i = 0; i < r; i++) begin
            repeat (4) t.push_back('{seq[i], 2'(r), 4'd0});
            repeat (2) t.push_back('{3'd0, 2'(r), 4'd0});
        end
        void'(t.pop_front());
        foreach (t[i]) exp_q.push_back(t[i]);
    endtask

    task automatic run_stream();
        obs_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            chk("play_show", 32'(show_code), 32'(e.show));
            chk("play_level", 32'(level), 32'(e.lvl));
            chk("play_step", 32'(step), 32'(e.stp));
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
    endtask

    task automatic press(input logic [2:0] c);
        @(posedge clk); #1 btn_valid = 1'b1; btn_code = c;
        @(posedge clk); #1 btn_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_rows(input int lo, input int hi);
        int cur = 0;
        for (int i = lo; i <= hi; i++) begin
            if (rows[i].round != cur) begin
                cur = rows[i].round;
                push_play(cur - 1, cur, 0);
                run_stream();
            end
            press(rows[i].code);
            chk_outs($sformatf("row%0d", i), rows[i].stp, 3'd0, rows[i].lvl, rows[i].w, rows[i].f);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        rand_q.delete();
        seq.delete();
    endtask

    initial begin
        bit lit;
        // {round, press, step, level, win, fail} after each press
        rows[0] = '{1, 3'd3, 4'd1, 2'd1, 1'b0, 1'b0};
        rows[1] = '{1, 3'd2, 4'd1, 2'd1, 1'b0, 1'b0};
        rows[2] = '{2, 3'd2, 4'd0, 2'd2, 1'b0, 1'b0};
        rows[3] = '{2, 3'd4, 4'd1, 2'd2, 1'b0, 1'b0};
        rows[4] = '{3, 3'd2, 4'd0, 2'd3, 1'b0, 1'b0};
        rows[5] = '{3, 3'd4, 4'd0, 2'd3, 1'b0, 1'b0};
        rows[6] = '{3, 3'd1, 4'd0, 2'd3, 1'b1, 1'b0};
        rows[7] = '{1, 3'd2, 4'd1, 2'd1, 1'b0, 1'b0};
        rows[8] = '{2, 3'd2, 4'd0, 2'd2, 1'b0, 1'b0};
        rows[9] = '{2, 3'd3, 4'd0, 2'd2, 1'b0, 1'b1};

        #2 chk_outs("reset", 4'd0, 3'd0, 2'd0, 1'b0, 1'b0);
        #10 rst = 1'b1;

        // asynchronous reset while a code is lit
        give_code(3'd3);
        pulse_start();
        chk_outs("t1_start", 4'd1, 3'd0, 2'd0, 1'b0, 1'b0);
        lit = 0;
        for (int k = 0; k < 20 && !lit; k++) begin
            @(negedge clk);
            lit = (show_code != 3'd0);
        end
        chk("t1_show_lit", 32'(show_code), 32'd3);
        @(negedge clk); #2 rst = 1'b0;
        #1 chk_outs("t1_async_rst", 4'd0, 3'd0, 2'd0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        rand_q.delete();
        seq.delete();

        // single round, code 3
        give_code(3'd3);
        pulse_start();
        chk_outs("t2_start", 4'd1, 3'd0, 2'd0, 1'b0, 1'b0);
        run_rows(0, 0);
        do_reset();

        // full game to WIN with 2,4,1
        give_code(3'd2); give_code(3'd4); give_code(3'd1);
        pulse_start();
        chk_outs("t3_start", 4'd1, 3'd0, 2'd0, 1'b0, 1'b0);
        run_rows(1, 6);
        @(negedge clk) chk_outs("t3_win_hold", 4'd0, 3'd0, 2'd3, 1'b1, 1'b0);

        // fail on a wrong second press at level 2
        seq.delete();
        give_code(3'd2); give_code(3'd4);
        pulse_start();
        chk_outs("t4_start", 4'd1, 3'd0, 2'd0, 1'b0, 1'b0);
        run_rows(7, 9);
        @(negedge clk) chk_outs("t4_fail_hold", 4'd0, 3'd0, 2'd2, 1'b0, 1'b1);

        // restart from FAIL; first random value is out of range and discarded
        seq.delete();
        give_code(3'd0); give_code(3'd4); give_code(3'd1);
        pulse_start();
        chk_outs("t5_start", 4'd1, 3'd0, 2'd0, 1'b0, 1'b0);
        push_play(0, 1, 1);
        run_stream();

        // start during INPUT is ignored
        pulse_start();
        chk_outs("t6_start_ign", 4'd0, 3'd0, 2'd1, 1'b0, 1'b0);
        press(3'd4);
        chk_outs("t6_round1", 4'd1, 3'd0, 2'd1, 1'b0, 1'b0);
        // presses during playback are ignored
        push_play(1, 2, 0);
        fork
            run_stream();
            begin
                repeat (4) @(posedge clk);
                #1 btn_valid = 1'b1; btn_code = 3'd4;
                @(posedge clk); #1 btn_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1 btn_valid = 1'b1; btn_code = 3'd2;
                @(posedge clk); #1 btn_valid = 1'b0;
                repeat (5) @(posedge clk);
                #1 btn_valid = 1'b1; btn_code = 3'd3;
                @(posedge clk); #1 btn_valid = 1'b0;
            end
        join
        press(3'd4);
        chk_outs("t6_press1", 4'd0, 3'd0, 2'd2, 1'b0, 1'b0);
        press(3'd1);
        chk_outs("t6_press2", 4'd1, 3'd0, 2'd2, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
